// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage, decode stage and hazard unit.
package instruction_fetch_pkg;

   localparam int unsigned INSTR_W     = 32;
   localparam int unsigned PC_W        = 32;
   localparam int unsigned FETCH_CNT_W = 32;

   localparam logic [INSTR_W-1:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [PC_W-1:0]    PC_STEP          = 32'h0000_0004;
   localparam logic [PC_W-1:0]    PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   // IF/ID pipeline register payload
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc_plus4;
      logic               valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/instruction_memory.sv
// Read-only word-addressed instruction store; contents fixed at elaboration.
module instruction_memory
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned                       DEPTH      = 128,
   parameter logic [DEPTH-1:0][INSTR_W-1:0]     INIT_IMAGE = '0
) (
   input  logic [PC_W-3:0]    word_addr,
   output logic [INSTR_W-1:0] rdata_c
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic in_range_c;

   // Combinational read; addresses past the end of the image fetch a NOP
   always_comb begin
      in_range_c = (word_addr < (PC_W-2)'(DEPTH));
      rdata_c    = NOP_WORD;
      if (in_range_c) begin
         rdata_c = INIT_IMAGE[word_addr[AW-1:0]];
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, instruction read and IF/ID pipeline register.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned                        IMEM_DEPTH = 128,
   parameter logic [PC_W-1:0]                    RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [IMEM_DEPTH-1:0][INSTR_W-1:0] IMEM_IMAGE = '0
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Stall,
   input  logic                   Redirect,
   input  logic [PC_W-1:0]        RedirectTarget,
   output logic [PC_W-1:0]        PC_Out,
   output logic [INSTR_W-1:0]     Instruction_IF_ID,
   output logic [PC_W-1:0]        PCPlus4_IF_ID,
   output logic                   Valid_IF_ID,
   output logic [FETCH_CNT_W-1:0] FetchCount
);

   logic [PC_W-1:0]        pc_q, pc_d;
   logic [PC_W-1:0]        pc_plus4_c;
   logic [INSTR_W-1:0]     fetch_word_c;
   if_id_t                 if_id_q, if_id_d;
   logic [FETCH_CNT_W-1:0] fetch_count_q, fetch_count_d;

   instruction_memory #(
      .DEPTH      (IMEM_DEPTH),
      .INIT_IMAGE (IMEM_IMAGE)
   ) u_imem (
      .word_addr (pc_q[PC_W-1:2]),
      .rdata_c   (fetch_word_c)
   );

   // Sequential PC; the carry out is dropped so the PC wraps modulo 2^32
   assign pc_plus4_c = pc_q + PC_STEP;

   // Next-state selection: redirect beats stall, stall beats sequential fetch
   always_comb begin
      pc_d          = pc_q;
      if_id_d       = if_id_q;
      fetch_count_d = fetch_count_q;
      if (Redirect) begin
         pc_d    = RedirectTarget & PC_ALIGN_MASK;
         if_id_d = IF_ID_BUBBLE;
      end else if (!Stall) begin
         pc_d          = pc_plus4_c;
         if_id_d       = '{instr: fetch_word_c, pc_plus4: pc_plus4_c, valid: 1'b1};
         fetch_count_d = fetch_count_q + FETCH_CNT_W'(1);
      end
   end

   // State registers with synchronous reset that overrides stall and redirect
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_q          <= RESET_PC;
         if_id_q       <= IF_ID_BUBBLE;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         if_id_q       <= if_id_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign PC_Out            = pc_q;
   assign Instruction_IF_ID = if_id_q.instr;
   assign PCPlus4_IF_ID     = if_id_q.pc_plus4;
   assign Valid_IF_ID       = if_id_q.valid;
   assign FetchCount        = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected state, monitor compares.
module tb_instruction_fetch;

   localparam int unsigned DEPTH = 128;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef logic [DEPTH-1:0][31:0] image_t;

   // Program image: test-plan words first, arbitrary non-trivial words after
   function automatic image_t gen_image();
      image_t img;
      for (int i = 0; i < int'(DEPTH); i++) begin
         img[i] = 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B1);
      end
      img[0] = 32'h2008_0001;
      img[1] = 32'h2009_0002;
      img[2] = 32'h0109_5020;
      img[3] = 32'hAC0A_0000;
      return img;
   endfunction

   localparam image_t IMAGE = gen_image();

   logic        clk = 1'b1;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc_out;
   logic [31:0] instr_if_id;
   logic [31:0] pcp4_if_id;
   logic        valid_if_id;
   logic [31:0] fetch_count;

   instruction_fetch #(
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (RST_PC),
      .IMEM_IMAGE (IMAGE)
   ) dut (
      .Clk               (clk),
      .Rst               (rst),
      .Stall             (stall),
      .Redirect          (redirect),
      .RedirectTarget    (redirect_target),
      .PC_Out            (pc_out),
      .Instruction_IF_ID (instr_if_id),
      .PCPlus4_IF_ID     (pcp4_if_id),
      .Valid_IF_ID       (valid_if_id),
      .FetchCount        (fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcp4;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   fails  = 0;
   int   pushes = 0;
   int   pops   = 0;

   // Reference model state
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pcp4 = '0;
   logic        m_valid = 1'b0;
   logic [31:0] m_cnt = '0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at time %0t", name, act, req, $time);
      end
   endfunction

   // Fetch word as a program sees it: bytes past the image read as zero
   function automatic logic [31:0] mem_at(input logic [31:0] addr);
      if (addr < 32'(DEPTH * 4)) return IMAGE[int'(addr >> 2)];
      return 32'h0;
   endfunction

   // Drive one cycle of inputs and push the state expected after the next edge
   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; redirect = d; redirect_target = t;
      if (r) begin
         m_pc = RST_PC; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0;
      end else if (d) begin
         m_pc = {t[31:2], 2'b00}; m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!s) begin
         m_instr = mem_at(m_pc);
         m_pcp4  = m_pc + 32'd4;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 32'd1;
         m_pc    = m_pc + 32'd4;
      end
      e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid; e.cnt = m_cnt;
      sb.push_back(e);
      pushes++;
   endtask

   // Monitor: after each rising edge compare DUT outputs with the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            pops++;
            check("pc_out", pc_out, e.pc);
            check("instr", instr_if_id, e.instr);
            check("pcplus4", pcp4_if_id, e.pcp4);
            check("valid", 32'(valid_if_id), 32'(e.valid));
            check("fetch_count", fetch_count, e.cnt);
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      logic        r, s, d;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

      // Reset, then four free-running fetches
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      // Restart, fetch two words (PC=8), stall three cycles, release
      step(1, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      // Misaligned redirect while PC=12
      step(0, 0, 1, 32'h0000_0013);
      step(0, 0, 0, 0);
      // Redirect and stall together
      step(0, 1, 1, 32'h0000_0020);
      step(0, 0, 0, 0);
      // Multi-cycle redirect
      step(0, 0, 1, 32'h0000_0008);
      step(0, 1, 1, 32'h0000_000C);
      step(0, 0, 0, 0);
      // Past the end of the image
      step(0, 0, 1, 32'h0000_0400);
      repeat (2) step(0, 0, 0, 0);
      // Last in-range word then first out-of-range word
      step(0, 0, 1, 32'(DEPTH * 4 - 4));
      repeat (2) step(0, 0, 0, 0);
      // PC wrap
      step(0, 0, 1, 32'hFFFF_FFFC);
      repeat (3) step(0, 0, 0, 0);
      // Reset mid-run overriding stall and redirect
      step(1, 1, 1, 32'h0000_0040);
      repeat (3) step(0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) == 0);
         d = ($urandom_range(0, 5) == 0);
         s = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 32'($urandom_range(0, DEPTH * 4 - 1));
            1:       tgt = $urandom();
            2:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: tgt = 32'(DEPTH * 4 - 8) + 32'($urandom_range(0, 15));
         endcase
         step(r, s, d, tgt);
      end

      step(0, 1, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(pops), 32'(pushes));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
